// File: rtl/ac_compressor_sequencer.sv
// Compressor start/stop sequencer with fan pre-start, minimum on-time, fan overrun and lockout.
// Optional build macro AC_SEQ_FAN_RAMP_EN: fan_drive steps by one per tick instead of jumping.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no demand, fan toward 0, compressor off
// LOCKOUT  | anti-short-cycle hold-off, demand ignored (also the reset state)
// PRESTART | fan toward 1 before the compressor is allowed on
// RUN      | compressor on, fan follows the clamped demand (at least 1)
// OVERRUN  | compressor off, fan toward 1 to clear the coil, demand ignored
module ac_compressor_sequencer #(
    parameter int unsigned PRESTART_TICKS = 4,
    parameter int unsigned MIN_ON_TICKS   = 60,
    parameter int unsigned OVERRUN_TICKS  = 30,
    parameter int unsigned MIN_OFF_TICKS  = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] req_speed,
    output logic [2:0] fan_drive,
    output logic       comp_en,
    output logic       lockout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOCKOUT  = 3'd1,
        S_PRESTART = 3'd2,
        S_RUN      = 3'd3,
        S_OVERRUN  = 3'd4
    } state_t;

    localparam logic [7:0] PRESTART_LAST = 8'(PRESTART_TICKS - 1);
    localparam logic [7:0] MIN_ON_LAST   = 8'(MIN_ON_TICKS - 1);
    localparam logic [7:0] OVERRUN_LAST  = 8'(OVERRUN_TICKS - 1);
    localparam logic [7:0] MIN_OFF_LAST  = 8'(MIN_OFF_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       min_on_done_q, min_on_done_d;
    logic [2:0] fan_q, fan_d;
    logic       comp_en_q, comp_en_d;
    logic [2:0] tgt, run_tgt, goal;

    assign tgt     = (req_speed > 3'd4) ? 3'd4 : req_speed;
    assign run_tgt = (tgt == 3'd0) ? 3'd1 : tgt;

    always_comb begin
        state_d       = state_q;
        goal          = 3'd0;
        min_on_done_d = min_on_done_q;
        cnt_d         = cnt_q;
        fan_d         = fan_q;
        comp_en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tgt != 3'd0) state_d = S_PRESTART;
            end
            S_LOCKOUT: begin
                if (tick && cnt_q == MIN_OFF_LAST) state_d = S_IDLE;
            end
            S_PRESTART: begin
                goal = 3'd1;
                if (tgt == 3'd0) state_d = S_IDLE;
                else if (tick && cnt_q == PRESTART_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                goal = run_tgt;
                // the tick that completes the on-time may also release it
                if (tick && cnt_q == MIN_ON_LAST) min_on_done_d = 1'b1;
                if (tgt == 3'd0 && min_on_done_d) state_d = S_OVERRUN;
            end
            S_OVERRUN: begin
                goal = 3'd1;
                if (tick && cnt_q == OVERRUN_LAST) state_d = S_LOCKOUT;
            end
            default: begin
                state_d = S_LOCKOUT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d         = 8'd0;
            min_on_done_d = 1'b0;
        end else if (tick && !(state_q == S_RUN && cnt_q == MIN_ON_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end

`ifdef AC_SEQ_FAN_RAMP_EN
        if (tick) begin
            if (fan_q < goal) fan_d = fan_q + 3'd1;
            else if (fan_q > goal) fan_d = fan_q - 3'd1;
        end
`else
        fan_d = goal;
`endif

        // never enable the compressor without airflow
        comp_en_d = (state_d == S_RUN) && (fan_d != 3'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_LOCKOUT;
            cnt_q         <= 8'd0;
            min_on_done_q <= 1'b0;
            fan_q         <= 3'd0;
            comp_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            min_on_done_q <= min_on_done_d;
            fan_q         <= fan_d;
            comp_en_q     <= comp_en_d;
        end
    end

    assign state     = state_q;
    assign fan_drive = fan_q;
    assign comp_en   = comp_en_q;
    assign lockout   = (state_q == S_LOCKOUT) || (state_q == S_OVERRUN);

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Randomized and directed bench for ac_compressor_sequencer against a phase/elapsed-tick reference model.
// Honours AC_SEQ_FAN_RAMP_EN in the model so either build can be checked.
module tb_ac_compressor_sequencer;
    localparam int PRE  = 2;
    localparam int MON  = 4;
    localparam int OVR  = 2;
    localparam int MOFF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] req_speed = 3'd0;
    logic [2:0] fan_drive;
    logic [2:0] state;
    logic       comp_en;
    logic       lockout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ticks_driven = 0;

    // reference model: phase number, ticks seen in phase, fan and compressor
    int m_phase;
    int m_elapsed;
    int m_fan;
    int m_comp;

    ac_compressor_sequencer #(
        .PRESTART_TICKS(PRE),
        .MIN_ON_TICKS  (MON),
        .OVERRUN_TICKS (OVR),
        .MIN_OFF_TICKS (MOFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req_speed(req_speed),
        .fan_drive(fan_drive),
        .comp_en  (comp_en),
        .lockout  (lockout),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase   = 1;
        m_elapsed = 0;
        m_fan     = 0;
        m_comp    = 0;
    endfunction

    function automatic void model_clock(input bit tk, input int rq);
        int t, nxt, goal, seen;
        t    = (rq > 4) ? 4 : rq;
        seen = m_elapsed + (tk ? 1 : 0);
        nxt  = m_phase;
        case (m_phase)
            0: if (t != 0) nxt = 2;
            1: if (seen >= MOFF) nxt = 0;
            2: if (t == 0) nxt = 0; else if (seen >= PRE) nxt = 3;
            3: if (t == 0 && seen >= MON) nxt = 4;
            4: if (seen >= OVR) nxt = 1;
            default: nxt = 1;
        endcase
        if (m_phase == 3) goal = (t == 0) ? 1 : t;
        else if (m_phase == 2 || m_phase == 4) goal = 1;
        else goal = 0;
`ifdef AC_SEQ_FAN_RAMP_EN
        if (tk) begin
            if (m_fan < goal) m_fan = m_fan + 1;
            else if (m_fan > goal) m_fan = m_fan - 1;
        end
`else
        m_fan = goal;
`endif
        m_comp    = (nxt == 3) ? 1 : 0;
        m_elapsed = (nxt != m_phase) ? 0 : seen;
        m_phase   = nxt;
    endfunction

    function automatic bit next_is_tick();
        return (cyc % 4) == 3;
    endfunction

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic run_cycle(input int rq);
        bit tk;
        tk = next_is_tick();
        tick = tk;
        req_speed = 3'(rq);
        @(posedge clk);
        if (reset) model_clock(tk, rq);
        else model_reset();
        cyc++;
        if (tk) ticks_driven++;
        @(negedge clk);
        tick = 1'b0;
        chk("state", int'(state), m_phase);
        chk("fan_drive", int'(fan_drive), m_fan);
        chk("comp_en", int'(comp_en), m_comp);
        chk("lockout", int'(lockout), (m_phase == 1 || m_phase == 4) ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, i, on_ticks, rq;
        bit comp_seen;
        model_reset();
        @(negedge clk);
        chk("rst_state", int'(state), 1);
        chk("rst_fan", int'(fan_drive), 0);
        chk("rst_comp", int'(comp_en), 0);
        chk("rst_lockout", int'(lockout), 1);
        run_cycle(3);
        run_cycle(3);
        reset = 1'b1;

        // 1: power-up lockout then prestart then run
        n0 = ticks_driven; i = 0;
        while (comp_en !== 1'b1 && i < 200) begin run_cycle(3); i++; end
        chk("s1_ticks_to_comp_en", ticks_driven - n0, MOFF + PRE);

        // 2: demand drops right after start; minimum on-time holds
        on_ticks = 0;
        for (int k = 0; k < 60; k++) begin
            if (comp_en === 1'b1 && next_is_tick()) on_ticks++;
            run_cycle(0);
        end
        chk("s2_on_ticks", on_ticks, MON);
        chk("s2_final_idle", int'(state), 0);

        // 3: prestart abort
        comp_seen = 1'b0; i = 0;
        while (state !== 3'd2 && i < 20) begin run_cycle(2); i++; end
        run_cycle(2);
        run_cycle(0);
        chk("s3_abort_idle", int'(state), 0);
        chk("s3_abort_lockout", int'(lockout), 0);
        for (int k = 0; k < 12; k++) begin
            run_cycle(0);
            if (comp_en === 1'b1) comp_seen = 1'b1;
        end
        chk("s3_comp_never", int'(comp_seen), 0);

        // 4: clamp of out-of-range demand
        i = 0;
        while (comp_en !== 1'b1 && i < 100) begin run_cycle(7); i++; end
        chk("s4_fan_at_start", int'(fan_drive), 1);
        run_cycle(7);
`ifndef AC_SEQ_FAN_RAMP_EN
        chk("s4_fan_next_clk", int'(fan_drive), 4);
`endif
        for (int k = 0; k < 16; k++) run_cycle(7);
        chk("s4_fan_hold", int'(fan_drive), 4);

        // 5: asynchronous reset mid-run
        for (int k = 0; k < 8; k++) run_cycle(3);
        chk("s5_pre_fan", int'(fan_drive), 3);
        chk("s5_pre_comp", int'(comp_en), 1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("s5_async_comp", int'(comp_en), 0);
        chk("s5_async_fan", int'(fan_drive), 0);
        chk("s5_async_state", int'(state), 1);
        run_cycle(3);
        run_cycle(3);
        reset = 1'b1;
        n0 = ticks_driven; i = 0;
        while (comp_en !== 1'b1 && i < 200) begin run_cycle(3); i++; end
        chk("s5_ticks_to_restart", ticks_driven - n0, MOFF + PRE);

        // 6: demand held through overrun and lockout
        i = 0;
        while (state !== 3'd4 && i < 60) begin run_cycle(0); i++; end
        chk("s6_in_overrun", int'(state), 4);
        n0 = ticks_driven; i = 0;
        while (comp_en !== 1'b1 && i < 200) begin run_cycle(4); i++; end
        chk("s6_ticks_to_restart", ticks_driven - n0, OVR + MOFF + PRE);

        // random demand against the model
        rq = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7) == 0)
                rq = ($urandom_range(2) == 0) ? 0 : int'($urandom_range(7, 1));
            run_cycle(rq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
